// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: FSM state encoding and pc_in_sel codes.
package pc_pkg;

    typedef enum logic [2:0] {
        RST_RD = 3'd0,
        RST_LD = 3'd1,
        RUN    = 3'd2,
        IRQ_RD = 3'd3,
        IRQ_LD = 3'd4
    } state_t;

    localparam logic [1:0] SEL_SWI    = 2'd0;
    localparam logic [1:0] SEL_STACK  = 2'd1;
    localparam logic [1:0] SEL_BRANCH = 2'd2;
    localparam logic [1:0] SEL_SRST   = 2'd3;

    // States in which the data-memory read port is borrowed for a vector fetch.
    function automatic logic is_vec_state(state_t s);
        return (s == RST_RD) || (s == IRQ_RD);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector: sequential increment or redirect target,
// plus decode of the soft-interrupt and soft-reset requests.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_src,
    input  logic [1:0]        pc_in_sel,
    input  logic [ADDR_W-1:0] stack_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] next_pc,
    output logic              swi,
    output logic              srst
);

    always_comb begin
        // Soft interrupt / soft reset fall through to pc + 1, which is the
        // return address an interrupt entry must capture in that case.
        next_pc = pc + ADDR_W'(1);
        if (pc_src) begin
            if (pc_in_sel == SEL_STACK) begin
                next_pc = stack_addr;
            end else if (pc_in_sel == SEL_BRANCH) begin
                next_pc = branch_addr;
            end
        end
    end

    assign swi  = pc_src && (pc_in_sel == SEL_SWI);
    assign srst = pc_src && (pc_in_sel == SEL_SRST);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC select, reset/interrupt vector fetch.
// Optional macro PC_WRAP_TRAP_EN enables the sticky wrap_err flag on sequential wrap.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              pc_src,
    input  logic [1:0]        pc_in_sel,
    input  logic [ADDR_W-1:0] stack_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              irq_req,
    input  logic              irq_en,
    input  logic [ADDR_W-1:0] vec_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              pc_valid,
    output logic              vec_rd,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              irq_ack,
    output logic [ADDR_W-1:0] ret_addr,
    output logic              wrap_err
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              pc_valid_reg, pc_valid_next;
    logic              irq_ack_reg, irq_ack_next;
    logic [ADDR_W-1:0] ret_addr_reg, ret_addr_next;

    logic [ADDR_W-1:0] sel_pc;
    logic              swi;
    logic              srst;
    logic              run_go;
    logic              irq_take;

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_next_sel (
        .pc          (pc_reg),
        .pc_src      (pc_src),
        .pc_in_sel   (pc_in_sel),
        .stack_addr  (stack_addr),
        .branch_addr (branch_addr),
        .next_pc     (sel_pc),
        .swi         (swi),
        .srst        (srst)
    );

    assign run_go   = (state_reg == RUN) && !stall;
    assign irq_take = (irq_req && irq_en) || swi;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pc_valid_next = pc_valid_reg;
        irq_ack_next  = 1'b0;
        ret_addr_next = ret_addr_reg;
        unique case (state_reg)
            RST_RD: begin
                if (!stall) begin
                    state_next = RST_LD;
                end
            end
            RST_LD: begin
                pc_next       = vec_rdata;
                pc_valid_next = 1'b1;
                state_next    = RUN;
            end
            RUN: begin
                if (!stall) begin
                    // Hardware and soft interrupts share one entry and one ack.
                    if (irq_take) begin
                        ret_addr_next = sel_pc;
                        irq_ack_next  = 1'b1;
                        pc_valid_next = 1'b0;
                        state_next    = IRQ_RD;
                    end else if (srst) begin
                        pc_valid_next = 1'b0;
                        state_next    = RST_RD;
                    end else begin
                        pc_next = sel_pc;
                    end
                end
            end
            IRQ_RD: begin
                if (!stall) begin
                    state_next = IRQ_LD;
                end
            end
            IRQ_LD: begin
                pc_next       = vec_rdata;
                pc_valid_next = 1'b1;
                state_next    = RUN;
            end
            default: begin
                pc_valid_next = 1'b0;
                state_next    = RST_RD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= RST_RD;
            pc_reg       <= '0;
            pc_valid_reg <= 1'b0;
            irq_ack_reg  <= 1'b0;
            ret_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pc_valid_reg <= pc_valid_next;
            irq_ack_reg  <= irq_ack_next;
            ret_addr_reg <= ret_addr_next;
        end
    end

`ifdef PC_WRAP_TRAP_EN
    logic wrap_err_reg, wrap_err_next;
    logic wrap_set, wrap_clr;

    // Only a plain sequential step from all-ones counts; redirects to 0 do not.
    assign wrap_set = run_go && !irq_take && !pc_src && (&pc_reg);
    assign wrap_clr = run_go && !irq_take && srst;
    assign wrap_err_next = (wrap_err_reg || wrap_set) && !wrap_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_err_reg <= 1'b0;
        end else begin
            wrap_err_reg <= wrap_err_next;
        end
    end

    assign wrap_err = wrap_err_reg;
`else
    logic unused_run_go;
    assign unused_run_go = run_go;
    assign wrap_err      = 1'b0;
`endif

    // The read strobe is gated by rst_n so it drops the instant reset asserts.
    assign vec_rd   = rst_n && is_vec_state(state_reg);
    assign vec_addr = !vec_rd ? '0 : ((state_reg == IRQ_RD) ? IRQ_VEC : RESET_VEC);

    assign pc       = pc_reg;
    assign pc_valid = pc_valid_reg;
    assign irq_ack  = irq_ack_reg;
    assign ret_addr = ret_addr_reg;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parameterised program-counter unit: owns the PC register, next-PC selection, and the vector-fetch sequences for reset and interrupt.
- Reset target is fetched from memory M[RESET_VEC]; interrupt target from M[IRQ_VEC].
- Sits at the head of the fetch stage. Drives the instruction-memory address, and borrows the data-memory read port for the vector fetches.
- Generalises the combinational next-PC select into a stateful unit with stall, interrupt entry and return-address capture.

Parameters:
- ADDR_W, 8, PC/address width in bits.
- RESET_VEC, 0, memory address holding the reset target.
- IRQ_VEC, 1, memory address holding the interrupt target.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; sequencer does not advance.
- pc_src  in  1  1 = redirect per pc_in_sel; 0 = sequential.
- pc_in_sel  in  2  0 = soft interrupt, 1 = stack_addr, 2 = branch_addr, 3 = soft reset.
- stack_addr  in  ADDR_W  return target X[++sp].
- branch_addr  in  ADDR_W  R[rb].
- irq_req  in  1  level interrupt request.
- irq_en  in  1  global interrupt enable.
- vec_rdata  in  ADDR_W  memory read data; valid 1 cycle after vec_rd.
- pc  out  ADDR_W  current fetch address.
- pc_valid  out  1  pc is a legal fetch address; low during vector sequences.
- vec_rd  out  1  vector read strobe.
- vec_addr  out  ADDR_W  vector read address.
- irq_ack  out  1  one-cycle pulse on interrupt entry.
- ret_addr  out  ADDR_W  address to push on interrupt entry; valid while irq_ack = 1.
- wrap_err  out  1  see Optional Feature.

Behaviour:
- FSM states: RST_RD, RST_LD, RUN, IRQ_RD, IRQ_LD.
- Reset (rst_n low, asynchronous) sets:
  - state = RST_RD;
  - pc = 0, pc_valid = 0;
  - vec_rd = 0, vec_addr = 0;
  - irq_ack = 0, ret_addr = 0, wrap_err = 0.
- RST_RD:
  - vec_rd = 1, vec_addr = RESET_VEC.
  - Next state RST_LD, unless stall is high (then stay in RST_RD).
- RST_LD:
  - pc <= vec_rdata, pc_valid <= 1.
  - Next state RUN. Stall is ignored in this state.
- RUN, evaluated in priority order on each edge:
  1. stall = 1: pc holds; no irq entry; redirect inputs ignored.
  2. Interrupt entry. Taken when (irq_req & irq_en) = 1, or pc_src = 1 with pc_in_sel = 0.
     - ret_addr <= the next-PC that would otherwise have loaded: the redirect target if pc_src = 1 with sel 1/2, else pc + 1.
     - irq_ack <= 1 for one cycle; pc_valid <= 0; next state IRQ_RD.
  3. pc_src = 1, sel = 3 (soft reset): pc_valid <= 0; next state RST_RD.
  4. pc_src = 1, sel = 1: pc <= stack_addr. sel = 2: pc <= branch_addr.
  5. Otherwise pc <= pc + 1, modulo 2^ADDR_W.
- IRQ_RD: vec_rd = 1, vec_addr = IRQ_VEC. Stall is honoured here.
- IRQ_LD: pc <= vec_rdata, pc_valid <= 1; next state RUN.
- irq_req is not sampled outside RUN. A request still pending on return to RUN is taken on the next unstalled cycle; there is no internal nesting mask.
- A hardware irq and a soft interrupt in the same cycle produce a single entry with a single irq_ack.
- Latency:
  - reset deassert to first valid pc: 2 unstalled cycles;
  - interrupt entry: 2 cycles of pc_valid = 0;
  - redirect: pc updates on the next edge.
- pc holds its last value during RST_RD/RST_LD and IRQ_RD/IRQ_LD.

Optional Feature:
- Macro: PC_WRAP_TRAP_EN.
- Defined: a sequential increment from all-ones sets a sticky wrap_err = 1. It clears only on rst_n or on a soft reset (sel = 3). Redirects to address 0 do not set it.
- Undefined: wrap_err is tied to 0 and the PC wraps silently.

Decomposition:
- Shared package pc_pkg holds:
  - state enum (RST_RD, RST_LD, RUN, IRQ_RD, IRQ_LD);
  - pc_in_sel encodings SEL_SWI = 0, SEL_STACK = 1, SEL_BRANCH = 2, SEL_SRST = 3.
- One sub-module is natural: pc_next_sel, the combinational next-PC/redirect-target selector. The FSM and the PC register stay in pc_unit.

Test Plan:
- Boot: vec_rdata = 0x40 during RST_LD -> pc_valid rises on the 2nd edge after rst_n deasserts, pc = 0x40; then 0x41, 0x42 on subsequent edges.
- Redirect: pc = 0x10, pc_src = 1, sel = 2, branch_addr = 0x80 -> pc = 0x80 next edge. With sel = 1, stack_addr = 0x22 -> pc = 0x22.
- Interrupt:
  - Setup: pc = 0x30, irq_req = 1, irq_en = 1, IRQ_VEC data = 0xC0.
  - Expected: irq_ack pulses once with ret_addr = 0x31; vec_addr = 1; pc_valid low for 2 cycles; then pc = 0xC0.
- Stall and mask:
  - stall = 1 with irq pending -> pc frozen, no irq_ack.
  - stall released -> entry taken.
  - irq_en = 0 -> irq ignored, pc increments.
- Simultaneous events: irq with branch to 0x55 in the same cycle -> a single entry with ret_addr = 0x55. Soft reset mid-run -> vec_addr = 0, pc reloads from M[0].
- Async reset asserted during IRQ_RD -> all outputs return to reset values immediately. With PC_WRAP_TRAP_EN, pc = 0xFF incrementing -> pc = 0x00 and wrap_err = 1 (sticky).
